// File: rtl/tdet_stim_sig_engine.sv
// Stimulus driver and MISR response compactor for one benchmark DUT, ending with a golden-signature compare.
// Optional build macro TDET_TRACE_EN adds the trace_valid/trace_data per-vector trace ports.
module tdet_stim_sig_engine #(
  parameter int unsigned N_W    = 1,
  parameter int unsigned OUT_W  = 1,
  parameter int unsigned SIG_W  = 8,
  parameter logic [SIG_W-1:0] POLY = SIG_W'(8'h1D),
  parameter int unsigned SETTLE = 1,
  parameter int unsigned CNT_W  = 17
) (
  input  logic             CK,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] pat_count,
  input  logic [SIG_W-1:0] golden_sig,
  output logic [N_W-1:0]   stim,
  input  logic [OUT_W-1:0] dut_out,
  output logic             busy,
  output logic             done,
  output logic [SIG_W-1:0] sig,
  output logic             mismatch
`ifdef TDET_TRACE_EN
  ,
  output logic                 trace_valid,
  output logic [N_W+OUT_W-1:0] trace_data
`endif
);

  typedef enum logic [1:0] {IDLE, HOLD, SAMPLE, FIN} state_e;

  // With no settle window each pattern is just its sample cycle, so HOLD is skipped entirely.
  localparam state_e     FIRST_STATE = (SETTLE == 0) ? SAMPLE : HOLD;
  localparam logic [7:0] HOLD_LAST   = (SETTLE == 0) ? 8'd0 : 8'(SETTLE - 1);

  state_e           state_q, state_d;
  logic [N_W-1:0]   stim_q, stim_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic [SIG_W-1:0] golden_q, golden_d;
  logic [CNT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [7:0]       hold_cnt_q, hold_cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             mismatch_q, mismatch_d;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves one unassigned (no latches).
    state_d    = state_q;
    stim_d     = stim_q;
    sig_d      = sig_q;
    golden_d   = golden_q;
    pat_d      = pat_q;
    idx_d      = idx_q;
    hold_cnt_d = hold_cnt_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    mismatch_d = mismatch_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          pat_d      = pat_count;
          golden_d   = golden_sig;
          sig_d      = '0;
          mismatch_d = 1'b0;
          stim_d     = '0;
          hold_cnt_d = '0;
          idx_d      = '0;
          busy_d     = 1'b1;
          state_d    = (pat_count == '0) ? FIN : FIRST_STATE;
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          state_d    = SAMPLE;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      SAMPLE: begin
        sig_d = {sig_q[SIG_W-2:0], 1'b0}
              ^ (sig_q[SIG_W-1] ? POLY : '0)
              ^ SIG_W'(dut_out);
        idx_d = idx_q + CNT_W'(1);
        if (idx_d == pat_q) begin
          state_d = FIN;
        end else begin
          stim_d  = stim_q + N_W'(1);
          state_d = FIRST_STATE;
        end
      end
      FIN: begin
        done_d     = 1'b1;
        busy_d     = 1'b0;
        mismatch_d = (sig_q != golden_q);
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CK) begin
    if (reset) begin
      state_q    <= IDLE;
      stim_q     <= '0;
      sig_q      <= '0;
      golden_q   <= '0;
      pat_q      <= '0;
      idx_q      <= '0;
      hold_cnt_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      stim_q     <= stim_d;
      sig_q      <= sig_d;
      golden_q   <= golden_d;
      pat_q      <= pat_d;
      idx_q      <= idx_d;
      hold_cnt_q <= hold_cnt_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign stim     = stim_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sig      = sig_q;
  assign mismatch = mismatch_q;

`ifdef TDET_TRACE_EN
  // Marks exactly the cycle in which the response is folded into the signature.
  assign trace_valid = (state_q == SAMPLE);
  assign trace_data  = {stim_q, dut_out};
`endif

endmodule

// File: tb/tb_tdet_stim_sig_engine.sv
// Randomized self-checking bench for tdet_stim_sig_engine against a pattern-list/arithmetic MISR model.
// Builds with or without TDET_TRACE_EN; trace pulses are counted when the macro is defined.
module tb_tdet_stim_sig_engine;

  localparam int N_W    = 1;
  localparam int OUT_W  = 1;
  localparam int SIG_W  = 8;
  localparam int SETTLE = 1;
  localparam int CNT_W  = 17;

  logic             CK = 1'b0;
  logic             reset;
  logic             start;
  logic [CNT_W-1:0] pat_count;
  logic [SIG_W-1:0] golden_sig;
  logic [N_W-1:0]   stim;
  logic [OUT_W-1:0] dut_out;
  logic             busy;
  logic             done;
  logic [SIG_W-1:0] sig;
  logic             mismatch;
  logic [1:0]       truth;
`ifdef TDET_TRACE_EN
  logic                 trace_valid;
  logic [N_W+OUT_W-1:0] trace_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CK = ~CK;

  // Behavioural stand-in for the benchmark DUT: a truth table indexed by the applied pattern.
  assign dut_out = truth[stim];

  tdet_stim_sig_engine #(
    .N_W(N_W), .OUT_W(OUT_W), .SIG_W(SIG_W), .POLY(8'h1D), .SETTLE(SETTLE), .CNT_W(CNT_W)
  ) u_dut (
    .CK(CK),
    .reset(reset),
    .start(start),
    .pat_count(pat_count),
    .golden_sig(golden_sig),
    .stim(stim),
    .dut_out(dut_out),
    .busy(busy),
    .done(done),
    .sig(sig),
    .mismatch(mismatch)
`ifdef TDET_TRACE_EN
    ,
    .trace_valid(trace_valid),
    .trace_data(trace_data)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Pattern k is k mod 2; response is truth[pattern]; signature step done in integer arithmetic.
  function automatic logic [7:0] model_sig(input int p, input logic [1:0] tt);
    int s;
    s = 0;
    for (int k = 0; k < p; k++) begin
      s = ((s * 2) % 256) ^ ((s >= 128) ? 'h1D : 0) ^ int'(tt[k % 2]);
    end
    return 8'(s);
  endfunction

  task automatic run_case(input int p, input logic [7:0] g, input logic [1:0] tt,
                          input bit poke_busy, input bit poke_fin);
    int         last;
    int         trace_cnt;
    logic [7:0] exp_sig;
    truth     = tt;
    exp_sig   = model_sig(p, tt);
    last      = p * (SETTLE + 1);
    trace_cnt = 0;
    @(posedge CK); #1;
    start      = 1'b1;
    pat_count  = CNT_W'(p);
    golden_sig = g;
    @(posedge CK); #1;
    pat_count  = CNT_W'($urandom);
    golden_sig = 8'($urandom);
    for (int j = 0; j <= last; j++) begin
      start = 1'b0;
      check("busy_run", 32'(busy), 32'(1));
      check("done_early", 32'(done), 32'(0));
      if (j < last) check("stim_seq", 32'(stim), 32'((j / (SETTLE + 1)) % 2));
`ifdef TDET_TRACE_EN
      if (trace_valid) trace_cnt++;
`endif
      if (poke_busy && j == 1) begin
        start     = 1'b1;
        pat_count = CNT_W'(5);
      end
      if (poke_fin && j == last) start = 1'b1;
      @(posedge CK); #1;
    end
    start = 1'b0;
    check("done_pulse", 32'(done), 32'(1));
    check("busy_end", 32'(busy), 32'(0));
    check("sig_final", 32'(sig), 32'(exp_sig));
    check("mismatch", 32'(mismatch), 32'(exp_sig != g));
    check("stim_last", 32'(stim), 32'((p == 0) ? 0 : (p - 1) % 2));
`ifdef TDET_TRACE_EN
    check("trace_cnt", 32'(trace_cnt), 32'(p));
`endif
    @(posedge CK); #1;
    check("done_one_cycle", 32'(done), 32'(0));
    check("idle_after_fin", 32'(busy), 32'(0));
    check("sig_held", 32'(sig), 32'(exp_sig));
    check("mismatch_held", 32'(mismatch), 32'(exp_sig != g));
  endtask

  task automatic reset_mid_hold();
    bit saw_done;
    truth = 2'b11;
    @(posedge CK); #1;
    start      = 1'b1;
    pat_count  = CNT_W'(3);
    golden_sig = 8'h00;
    @(posedge CK); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge CK); #1;
    end
    check("pre_reset_sig", 32'(sig), 32'(1));
    reset = 1'b1;
    @(posedge CK); #1;
    reset = 1'b0;
    check("abort_busy", 32'(busy), 32'(0));
    check("abort_sig", 32'(sig), 32'(0));
    check("abort_stim", 32'(stim), 32'(0));
    check("abort_done", 32'(done), 32'(0));
    saw_done = 1'b0;
    repeat (10) begin
      @(posedge CK); #1;
      if (done || busy) saw_done = 1'b1;
    end
    check("no_done_after_abort", 32'(saw_done), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int         p;
    logic [1:0] tt;
    logic [7:0] g;
    reset      = 1'b1;
    start      = 1'b0;
    pat_count  = '0;
    golden_sig = '0;
    truth      = 2'b00;
    repeat (2) @(posedge CK);
    #1;
    check("rst_stim", 32'(stim), 32'(0));
    check("rst_busy", 32'(busy), 32'(0));
    check("rst_done", 32'(done), 32'(0));
    check("rst_sig", 32'(sig), 32'(0));
    check("rst_mismatch", 32'(mismatch), 32'(0));
    reset = 1'b0;

    run_case(2, 8'h03, 2'b11, 1'b0, 1'b0);
    check("spec_tied1_sig", 32'(sig), 32'(8'h03));
    run_case(2, 8'h03, 2'b00, 1'b0, 1'b0);
    check("spec_tied0_mismatch", 32'(mismatch), 32'(1));
    run_case(3, 8'h05, 2'b01, 1'b0, 1'b0);
    check("spec_inv_sig", 32'(sig), 32'(8'h05));
    run_case(0, 8'h00, 2'b11, 1'b0, 1'b0);
    run_case(0, 8'h5A, 2'b11, 1'b0, 1'b1);
    reset_mid_hold();
    run_case(4, 8'h0F, 2'b10, 1'b1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      p  = int'($urandom_range(0, 9));
      tt = 2'($urandom);
      g  = ($urandom_range(0, 1) == 1) ? model_sig(p, tt) : 8'($urandom);
      run_case(p, g, tt, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
